// File: rtl/ymux_arb_if.sv
// rtl/ymux_arb_if.sv - handshake bundle for the ymux_arb registered arbiter/mux
//
// Purpose: groups the N producer channels, the select/mode controls and the
// single consumer port of ymux_arb so they travel as one port.
// Signals:
//   in_data   N*W  channel i data in bits [i*W+W-1 : i*W]
//   in_valid  N    channel i offers data
//   in_ready  N    channel i transfers this cycle (one-hot or zero)
//   sel       SELW channel chosen in fixed mode
//   mode      1    0 = fixed select, 1 = round-robin
//   out_data  W    registered selected data
//   out_src   SELW channel index that produced out_data
//   out_valid 1    output register holds data
//   out_ready 1    consumer accepts out_data this cycle
// Modports: master = producers/consumer side, slave = the arbiter itself.
interface ymux_arb_if #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SELW = 2
);
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [SELW-1:0] sel;
  logic            mode;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_src;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/ymux_arb.sv
// rtl/ymux_arb.sv - registered N-channel valid/ready mux with fixed or round-robin grant
//
// Purpose: picks one requesting channel per cycle and holds it in a single
// output register until the consumer accepts it. A drain and a new load can
// happen on the same edge, so a continuously ready consumer sees 1 word/cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    ymux_arb_if.slave (in_data/in_valid/in_ready, sel, mode,
//          out_data/out_src/out_valid/out_ready)
// Build option: define YMUX_ARB_RR_EN to compile in the round-robin pointer
// and honour `mode`; without it the block is fixed-select only and `mode`
// is ignored (port list unchanged).
module ymux_arb #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  ymux_arb_if.slave   bus
);

  // Output register occupancy doubles as the state; out_valid is the state bit.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic            ld;
  logic            load_word;
  logic            use_rr;

  logic            fx_vld;
  logic [SELW-1:0] fx_idx;
  logic            rr_vld;
  logic [SELW-1:0] rr_idx;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;

  logic [W-1:0]    gnt_data;
  logic [N-1:0]    ready;
  logic [W-1:0]    data_q;
  logic [SELW-1:0] src_q;

  // Fixed select: sel values with no matching channel (sel >= N) never hit,
  // which is exactly the "no request" behaviour for non-power-of-2 N.
  always_comb begin
    fx_vld = 1'b0;
    fx_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
        fx_vld = 1'b1;
        fx_idx = SELW'(i);
      end
    end
  end

`ifdef YMUX_ARB_RR_EN
  logic [SELW-1:0] ptr;

  // Circular search starting after ptr, done as two linear passes:
  // first the indices above ptr, then wrap to the indices at or below it.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!rr_vld && bus.in_valid[i] && SELW'(i) > ptr) begin
        rr_vld = 1'b1;
        rr_idx = SELW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!rr_vld && bus.in_valid[i] && SELW'(i) <= ptr) begin
        rr_vld = 1'b1;
        rr_idx = SELW'(i);
      end
    end
  end

  assign use_rr = bus.mode;

  // ptr only moves on a round-robin load; fixed-mode grants leave it alone
  // so switching back to round-robin resumes where it left off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= SELW'(N - 1);
    end else if (load_word && use_rr) begin
      ptr <= gnt_idx;
    end
  end
`else
  logic unused_mode;

  assign unused_mode = bus.mode;
  assign use_rr      = 1'b0;
  assign rr_vld      = 1'b0;
  assign rr_idx      = '0;
`endif

  assign gnt_vld = use_rr ? rr_vld : fx_vld;
  assign gnt_idx = use_rr ? rr_idx : fx_idx;

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data = bus.in_data[i*W +: W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and load decision. The register may be reloaded whenever it
  // is empty or being drained this cycle, which gives bubble-free streaming.
  always_comb begin
    state_nx  = state;
    ld        = (state == EMPTY) || bus.out_ready;
    load_word = ld && gnt_vld;
    if (ld) begin
      state_nx = gnt_vld ? FULL : EMPTY;
    end
  end

  // rst_n gates in_ready so no producer handshake completes on a reset edge.
  always_comb begin
    ready = '0;
    for (int i = 0; i < N; i++) begin
      ready[i] = rst_n && load_word && (gnt_idx == SELW'(i));
    end
  end

  // Data and source hold when the register empties without a new grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      src_q  <= '0;
    end else if (load_word) begin
      data_q <= gnt_data;
      src_q  <= gnt_idx;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.out_valid = (state == FULL);

endmodule

// File: doc/ymux_arb.md
# ymux_arb

Registered N-channel, W-bit multiplexer with valid/ready handshaking on every input and on the output. It is the sequential successor to the combinational 2:1 yMux in the datapath library. It selects one requesting channel per cycle, either by an explicit select or by round-robin arbitration. The selection is held in a single output register until the consumer accepts it. It sits between multiple producer stages and one shared consumer, such as a shared ALU operand port or writeback bus.

## Interface
- `W`, 32: data width per channel.
- `N`, 4: channel count, 2..16.
- `SELW`, 2: select width; must satisfy 2^SELW >= N.

- `clk` in 1: rising-edge clock.
- `rst_n` in 1: synchronous active-low reset, sampled on the `clk` rising edge.
- `in_data` in N*W: channel i occupies bits [i*W+W-1 : i*W].
- `in_valid` in N: channel i offers data.
- `in_ready` out N: channel i transfers this cycle; at most one bit is high (one-hot or zero).
- `sel` in SELW: channel chosen in fixed mode.
- `mode` in 1: 0 = fixed select, 1 = round-robin (see Configuration).
- `out_data` out W: registered selected data.
- `out_src` out SELW: index of the channel that produced `out_data`.
- `out_valid` out 1: output register holds data.
- `out_ready` in 1: consumer accepts `out_data` this cycle.

## Operation
- Two states, encoded by `out_valid`:
  - EMPTY (0).
  - FULL (1).
- Load enable: `ld = !out_valid || out_ready`.
- Grant, combinational from the current inputs:
  - Fixed mode: grant `sel` if `sel < N` and `in_valid[sel]`; otherwise no grant.
  - Round-robin mode: grant the first i with `in_valid[i]`, searching `ptr+1, ptr+2, …` modulo N, where `ptr` is the last granted index.
- `in_ready[g] = ld` for the granted channel g; all other `in_ready` bits are 0.
- On a clock edge with `ld` and a grant:
  - `out_data <= in_data[g]`, `out_src <= g`, `out_valid <= 1`.
  - In round-robin mode, `ptr <= g`.
- On a clock edge with `ld` and no grant: `out_valid <= 0`; `out_data` and `out_src` hold.
- FULL with `!out_ready`:
  - `out_data`, `out_src` and `out_valid` hold.
  - All `in_ready` bits are 0.
  - Changes on `sel`, `mode` or inputs have no effect on the outputs.
- `ptr` does not advance in fixed mode.
- Switching `mode` takes effect on the next grant decision with no flush; `ptr` keeps its value.
- `sel >= N` (possible when N is not a power of 2) is treated as no request.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_src`=0, `ptr`=N-1 (the first round-robin grant therefore searches from channel 0), `in_ready`=0.
- While `rst_n`=0, `in_ready`=0 regardless of inputs.
- Reset asserted mid-transfer discards the held word; no handshake completes on that edge.
- Latency: input transfer at edge k gives `out_valid`=1 with the data after edge k.
- Throughput: 1 word/cycle when `out_ready` is held at 1. A simultaneous drain and load in the same cycle is required, with no bubble.
- A transfer occurs on an edge where valid && ready are both high, for input and output alike.

## Configuration
- `YMUX_ARB_RR_EN` defined:
  - Round-robin logic and the `ptr` register are compiled in.
  - `mode` behaves as described above.
- `YMUX_ARB_RR_EN` undefined:
  - No `ptr` register; `mode` is ignored and the block is always in fixed mode.
  - The port list is unchanged.

## Test plan
- Reset: drive `rst_n`=0 with all `in_valid`=1. Required: `in_ready`=0000, `out_valid`=0, `out_data`=0. Release reset, fixed mode, `sel`=2, `in_data[2]`=32'hDEADBEEF. Required: `in_ready`=0100; after one edge `out_data`=DEADBEEF, `out_src`=2.
- Backpressure: FULL with `out_ready`=0 for 5 cycles while `sel` and `in_data` toggle. Required: `out_data`/`out_src` stable, `in_ready`=0000. Raise `out_ready`. Required: new word loaded on the same edge as the drain.
- Round-robin fairness (macro defined, N=4): all `in_valid`=1, `out_ready`=1 for 8 cycles. Required: `out_src` sequence 0,1,2,3,0,1,2,3.
- Round-robin skip: `in_valid`=1010 after reset. Required: grants 1,3,1,3. Then drop `in_valid[3]`. Required: grants 1,1.
- Fixed select with no request: `sel`=1, `in_valid`=1101, `out_ready`=1. Required: `in_ready`=0000 and `out_valid` goes to 0 after one edge. Also N=3 with `sel`=3: no grant.
- Random regression: 500 cycles of random data, valid, ready, `sel` and `mode`. A scoreboard checks every accepted input appears exactly once at the output, in order, with the correct `out_src`.
